// File: rtl/mor1kx_irq_conditioner.sv
// Interrupt input conditioning: per-line polarity fix, multi-flop synchroniser and
// consecutive-cycle glitch filter (macro MOR1KX_IRQ_GLITCH_FILTER_EN), plus rise strobes.
module mor1kx_irq_conditioner #(
  parameter int               WIDTH                    = 32,
  parameter int               OPTION_IRQ_SYNC_STAGES   = 2,
  parameter int               OPTION_IRQ_FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] OPTION_IRQ_INVERT        = '0,
  parameter logic [WIDTH-1:0] OPTION_IRQ_BYPASS        = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] irq_async_i,
  output logic [WIDTH-1:0] irq_o,
  output logic [WIDTH-1:0] irq_rise_o
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_d;

  // Polarity is normalised before the first flop so every later stage is active-high.
  assign raw = irq_async_i ^ OPTION_IRQ_INVERT;

  generate
    if (OPTION_IRQ_SYNC_STAGES < 2 || OPTION_IRQ_FILTER_CYCLES < 1) begin : g_bad_param
      initial begin
        $display("mor1kx_irq_conditioner: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
        $finish;
      end
      assign q = '0;
    end else begin : g_lines
      for (genvar i = 0; i < WIDTH; i++) begin : g_line
        logic q_line;
        assign q[i] = q_line;

        if (OPTION_IRQ_BYPASS[i]) begin : g_bypass
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q_line <= 1'b0;
            else        q_line <= raw[i];
          end
        end else begin : g_cond
          logic [OPTION_IRQ_SYNC_STAGES-1:0] sync_ff;
          logic                              sync;

          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_ff <= '0;
            else        sync_ff <= {sync_ff[OPTION_IRQ_SYNC_STAGES-2:0], raw[i]};
          end
          assign sync = sync_ff[OPTION_IRQ_SYNC_STAGES-1];

`ifdef MOR1KX_IRQ_GLITCH_FILTER_EN
          localparam int CNT_W = $clog2(OPTION_IRQ_FILTER_CYCLES) + 1;
          logic [CNT_W-1:0] cnt;

          // Any sample agreeing with the current level restarts the qualification count.
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              cnt    <= '0;
              q_line <= 1'b0;
            end else if (sync == q_line) begin
              cnt <= '0;
            end else if (cnt == CNT_W'(OPTION_IRQ_FILTER_CYCLES - 1)) begin
              q_line <= sync;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`else
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q_line <= 1'b0;
            else        q_line <= sync;
          end
`endif
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_d <= '0;
    else        q_d <= q;
  end

  assign irq_o      = q;
  assign irq_rise_o = q & ~q_d;

endmodule

// File: tb/tb_mor1kx_irq_conditioner.sv
// Randomised and directed bench for mor1kx_irq_conditioner against a sample-history model.
module tb_mor1kx_irq_conditioner;

  localparam int          W   = 32;
  localparam int          S   = 2;
  localparam int          F   = 4;
  localparam logic [31:0] INV = 32'h0000_0001;
  localparam logic [31:0] BYP = 32'h8000_0000;
`ifdef MOR1KX_IRQ_GLITCH_FILTER_EN
  localparam int LAT = S + F;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT = S + 1;
  localparam bit FILT = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  irq_async;
  logic [W-1:0]  irq_o;
  logic [W-1:0]  irq_rise;

  always #5 clk = ~clk;

  mor1kx_irq_conditioner #(
    .WIDTH(W), .OPTION_IRQ_SYNC_STAGES(S), .OPTION_IRQ_FILTER_CYCLES(F),
    .OPTION_IRQ_INVERT(INV), .OPTION_IRQ_BYPASS(BYP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_async_i(irq_async),
    .irq_o(irq_o), .irq_rise_o(irq_rise)
  );

  // reference model: history of normalised samples, newest first
  logic [W-1:0] hist[$];
  logic [W-1:0] m_q;
  logic [W-1:0] exp_o;
  logic [W-1:0] exp_rise;
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic logic hist_bit(int j, int i);
    return (j < hist.size()) ? hist[j][i] : 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_q      = '0;
    exp_o    = '0;
    exp_rise = '0;
  endtask

  // Drive one cycle from a negedge; the model advances on the posedge.
  task automatic tick(input logic [W-1:0] d);
    logic [W-1:0] qn;
    logic         all_diff;
    irq_async = d;
    @(posedge clk);
    hist.push_front(d ^ INV);
    while (hist.size() > S + F + 1) void'(hist.pop_back());
    for (int i = 0; i < W; i++) begin
      if (BYP[i]) qn[i] = hist[0][i];
      else if (FILT) begin
        // level flips only when the last F synchronised samples all disagree with it
        all_diff = 1'b1;
        for (int j = 0; j < F; j++)
          if (hist_bit(S + j, i) == m_q[i]) all_diff = 1'b0;
        qn[i] = all_diff ? ~m_q[i] : m_q[i];
      end else qn[i] = hist_bit(S, i);
    end
    exp_rise = qn & ~m_q;
    m_q      = qn;
    exp_o    = qn;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_async = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({irq_o, irq_rise} !== 64'h0) $display("FAIL reset_hold: got o=%h rise=%h want 0", irq_o, irq_rise);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({irq_o, irq_rise} !== 64'h0) $display("FAIL reset_release: got o=%h rise=%h want 0", irq_o, irq_rise);
    else n_pass++;
    for (int c = 0; c < LAT + 3; c++) begin
      tick('0);
      n_checks++;
      if ({irq_o, irq_rise} !== {exp_o, exp_rise})
        $display("FAIL reset_idle c%0d: got o=%h rise=%h want o=%h rise=%h", c, irq_o, irq_rise, exp_o, exp_rise);
      else n_pass++;
    end
    n_checks++;
    if (irq_o !== 32'h0000_0001) $display("FAIL reset_inverted_idle: got %h want 00000001", irq_o);
    else n_pass++;
  endtask

  task automatic test_assert_latency();
    int first = 0;
    for (int c = 1; c <= LAT + 4; c++) begin
      tick(32'h0000_0008);
      n_checks++;
      if ({irq_o, irq_rise} !== {exp_o, exp_rise})
        $display("FAIL latency c%0d: got o=%h rise=%h want o=%h rise=%h", c, irq_o, irq_rise, exp_o, exp_rise);
      else n_pass++;
      if (first == 0 && irq_o[3]) begin
        first = c;
        n_checks++;
        if (irq_rise[3] !== 1'b1) $display("FAIL latency_strobe: got %b want 1", irq_rise[3]);
        else n_pass++;
      end
    end
    n_checks++;
    if (first != LAT) $display("FAIL latency_cycles: got %0d want %0d", first, LAT);
    else n_pass++;
    for (int c = 0; c < LAT + 2; c++) tick('0);
  endtask

  task automatic test_glitch();
    int hi;
    for (int w = 3; w <= 4; w++) begin
      hi = 0;
      for (int c = 0; c < 16; c++) begin
        tick(c < w ? 32'h0000_0020 : 32'h0);
        hi += int'(irq_o[5]);
        n_checks++;
        if ({irq_o, irq_rise} !== {exp_o, exp_rise})
          $display("FAIL glitch w%0d c%0d: got o=%h rise=%h want o=%h rise=%h", w, c, irq_o, irq_rise, exp_o, exp_rise);
        else n_pass++;
      end
      n_checks++;
      if (hi != ((FILT && w < F) ? 0 : w)) $display("FAIL glitch_width w%0d: got %0d high cycles", w, hi);
      else n_pass++;
    end
  endtask

  task automatic test_single_pulse();
    int hi = 0;
    int first = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(c == 1 ? 32'h0000_0002 : 32'h0);
      if (irq_o[1]) begin
        hi++;
        if (first == 0) first = c;
      end
      n_checks++;
      if ({irq_o, irq_rise} !== {exp_o, exp_rise})
        $display("FAIL pulse c%0d: got o=%h rise=%h want o=%h rise=%h", c, irq_o, irq_rise, exp_o, exp_rise);
      else n_pass++;
    end
    n_checks++;
    if (hi != (FILT ? 0 : 1) || first != (FILT ? 0 : S + 1))
      $display("FAIL pulse_shape: got high=%0d first=%0d", hi, first);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [W-1:0] d;
    for (int c = 0; c < 10; c++) begin
      d = (c % 2 == 0) ? 32'h8000_0000 : 32'h0;
      tick(d);
      n_checks++;
      if (irq_o[31] !== d[31] || irq_rise[31] !== d[31] || {irq_o, irq_rise} !== {exp_o, exp_rise})
        $display("FAIL bypass c%0d: got o=%h rise=%h want o=%h rise=%h", c, irq_o, irq_rise, exp_o, exp_rise);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int first = 0;
    for (int c = 0; c < LAT + 2; c++) tick(32'h0000_0080);
    n_checks++;
    if (irq_o[7] !== 1'b1) $display("FAIL mid_reset_pre: got %b want 1", irq_o[7]);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({irq_o, irq_rise} !== 64'h0) $display("FAIL mid_reset_async: got o=%h rise=%h want 0", irq_o, irq_rise);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      tick(32'h0000_0080);
      if (first == 0 && irq_o[7]) first = c;
      n_checks++;
      if ({irq_o, irq_rise} !== {exp_o, exp_rise})
        $display("FAIL mid_reset c%0d: got o=%h rise=%h want o=%h rise=%h", c, irq_o, irq_rise, exp_o, exp_rise);
      else n_pass++;
    end
    n_checks++;
    if (first != LAT) $display("FAIL mid_reset_latency: got %0d want %0d", first, LAT);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] cur = '0;
    int           run[W];
    for (int i = 0; i < W; i++) run[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < W; i++) begin
        if (run[i] == 0) begin
          cur[i] = 1'($urandom_range(0, 1));
          run[i] = $urandom_range(1, 7);
        end
        run[i]--;
      end
      tick(cur);
      n_checks++;
      if ({irq_o, irq_rise} !== {exp_o, exp_rise})
        $display("FAIL random c%0d: got o=%h rise=%h want o=%h rise=%h", c, irq_o, irq_rise, exp_o, exp_rise);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_assert_latency();
    test_glitch();
    test_single_pulse();
    test_bypass();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
